// File: rtl/pkt_disassembler_if.sv
// Packet-in / event-out handshake bundle for the packet disassembler.
// The slave modport is the disassembler side, the master modport is the
// router/serialiser side that drives packets and accepts events.
interface pkt_disassembler_if #(
    parameter int PKT_BITS = 72
);
    logic [PKT_BITS-1:0] pkt_data_in;
    logic                pkt_vld_in;
    logic                pkt_rdy_out;
    logic [31:0]         evt_data_out;
    logic                evt_vld_out;
    logic                evt_rdy_in;

    modport slave (
        input  pkt_data_in,
        input  pkt_vld_in,
        input  evt_rdy_in,
        output pkt_rdy_out,
        output evt_data_out,
        output evt_vld_out
    );

    modport master (
        output pkt_data_in,
        output pkt_vld_in,
        output evt_rdy_in,
        input  pkt_rdy_out,
        input  evt_data_out,
        input  evt_vld_out
    );
endinterface

// File: rtl/pkt_disassembler.sv
// Multicast packet disassembler: filters incoming packets on parity, type and
// a programmable key/mask, then rebuilds a 32-bit event from masked, shifted
// key fields. Two-stage pipe: A holds the accepted key, B holds the event.
module pkt_disassembler #(
    parameter int NUM_MREGS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 mp_key_in,
    input  logic [31:0]                 mp_msk_in,
    input  logic [NUM_MREGS-1:0][31:0]  mp_fld_msk_in,
    input  logic [NUM_MREGS-1:0][5:0]   mp_fld_sft_in,
    input  logic                        cnt_clr_in,
    pkt_disassembler_if.slave           pkt_if,
    output logic [31:0]                 drop_cnt_out,
    output logic [31:0]                 perr_cnt_out
);

    // Odd parity over the header+key, extended over the payload when present.
    function automatic logic parity_ok(input logic [71:0] pkt);
        logic ok;
        if (pkt[1]) begin
            ok = ^pkt[71:0];
        end else begin
            ok = ^pkt[39:0];
        end
        return ok;
    endfunction

    // Two's complement shift: non-negative shifts right, negative shifts left.
    // A left shift by 32 clears the word.
    function automatic logic [31:0] field_shift(input logic [31:0] v, input logic [5:0] sft);
        logic [5:0]  amt;
        logic [31:0] r;
        amt = 6'd0 - sft;
        if (sft[5]) begin
            r = v << amt;
        end else begin
            r = v >> sft[4:0];
        end
        return r;
    endfunction

    logic        a_vld_q, a_vld_d;
    logic [31:0] a_key_q, a_key_d;
    logic        b_vld_q, b_vld_d;
    logic [31:0] b_data_q, b_data_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;
    logic [31:0] perr_cnt_q, perr_cnt_d;

    logic        rdy_s;
    logic        acc_s;
    logic        perr_s;
    logic        match_s;
    logic        keep_s;
    logic        a_move_s;
    logic [31:0] pkt_key_s;
    logic [31:0] evt_s;

    assign pkt_key_s = pkt_if.pkt_data_in[39:8];

    // Ready and handshake classification of the offered packet.
    always_comb begin
        rdy_s    = !reset && (!a_vld_q || !b_vld_q || pkt_if.evt_rdy_in);
        acc_s    = pkt_if.pkt_vld_in && rdy_s;
        perr_s   = !parity_ok(pkt_if.pkt_data_in);
        match_s  = (pkt_if.pkt_data_in[7:6] == 2'b00) &&
                   ((pkt_key_s & mp_msk_in) == mp_key_in);
        keep_s   = acc_s && !perr_s && match_s;
        a_move_s = a_vld_q && (!b_vld_q || pkt_if.evt_rdy_in);
    end

    // Event reconstruction: OR of every masked and shifted key field.
    always_comb begin
        evt_s = 32'd0;
        for (int i = 0; i < NUM_MREGS; i++) begin
            evt_s = evt_s | field_shift(a_key_q & mp_fld_msk_in[i], mp_fld_sft_in[i]);
        end
    end

    // Pipeline next state: A refills from kept packets, B refills from A.
    always_comb begin
        a_vld_d  = a_vld_q;
        a_key_d  = a_key_q;
        b_vld_d  = b_vld_q;
        b_data_d = b_data_q;
        if (a_move_s) begin
            b_vld_d  = 1'b1;
            b_data_d = evt_s;
        end else if (pkt_if.evt_rdy_in) begin
            b_vld_d  = 1'b0;
        end else begin
            b_vld_d  = b_vld_q;
        end
        if (keep_s) begin
            a_vld_d = 1'b1;
            a_key_d = pkt_key_s;
        end else if (a_move_s) begin
            a_vld_d = 1'b0;
        end else begin
            a_vld_d = a_vld_q;
        end
    end

    // Drop counters: clear wins over a same-cycle increment, otherwise wrap.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        perr_cnt_d = perr_cnt_q;
        if (cnt_clr_in) begin
            drop_cnt_d = 32'd0;
            perr_cnt_d = 32'd0;
        end else if (acc_s && perr_s) begin
            perr_cnt_d = perr_cnt_q + 32'd1;
        end else if (acc_s && !match_s) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // State registers with synchronous reset; reset empties the pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_vld_q    <= 1'b0;
            a_key_q    <= 32'd0;
            b_vld_q    <= 1'b0;
            b_data_q   <= 32'd0;
            drop_cnt_q <= 32'd0;
            perr_cnt_q <= 32'd0;
        end else begin
            a_vld_q    <= a_vld_d;
            a_key_q    <= a_key_d;
            b_vld_q    <= b_vld_d;
            b_data_q   <= b_data_d;
            drop_cnt_q <= drop_cnt_d;
            perr_cnt_q <= perr_cnt_d;
        end
    end

    assign pkt_if.pkt_rdy_out  = rdy_s;
    assign pkt_if.evt_vld_out  = b_vld_q;
    assign pkt_if.evt_data_out = b_data_q;
    assign drop_cnt_out        = drop_cnt_q;
    assign perr_cnt_out        = perr_cnt_q;

endmodule

// File: tb/tb_pkt_disassembler.sv
// Self-checking bench for pkt_disassembler: randomized packets checked against
// a behavioural model (parity by popcount, field extraction by 64-bit arithmetic).
module tb_pkt_disassembler;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       mp_key;
    logic [31:0]       mp_msk;
    logic [3:0][31:0]  mp_fld_msk;
    logic [3:0][5:0]   mp_fld_sft;
    logic              cnt_clr;
    logic [31:0]       drop_cnt;
    logic [31:0]       perr_cnt;

    pkt_disassembler_if #(.PKT_BITS(72)) pif ();

    pkt_disassembler #(.NUM_MREGS(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .mp_key_in     (mp_key),
        .mp_msk_in     (mp_msk),
        .mp_fld_msk_in (mp_fld_msk),
        .mp_fld_sft_in (mp_fld_sft),
        .cnt_clr_in    (cnt_clr),
        .pkt_if        (pif),
        .drop_cnt_out  (drop_cnt),
        .perr_cnt_out  (perr_cnt)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           acc_cyc  = 0;
    logic [31:0]  exp_drop = 32'd0;
    logic [31:0]  exp_perr = 32'd0;
    logic [31:0]  exp_q[$];
    logic [31:0]  got_q[$];
    int           got_cyc[$];
    int unsigned  cfg_msk[4];
    int           cfg_sft[4];
    int           stall_viol = 0;
    logic         prev_stall = 1'b0;
    logic [31:0]  prev_data  = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: records every output handshake and stall stability.
    always @(negedge clk) begin
        if (pif.evt_vld_out && pif.evt_rdy_in) begin
            got_q.push_back(pif.evt_data_out);
            got_cyc.push_back(cyc);
        end
        if (prev_stall && !reset && (!pif.evt_vld_out || pif.evt_data_out !== prev_data))
            stall_viol <= stall_viol + 1;
        prev_stall <= pif.evt_vld_out && !pif.evt_rdy_in && !reset;
        prev_data  <= pif.evt_data_out;
    end

    function automatic logic [71:0] make_pkt(input logic [31:0] key, input logic [1:0] typ,
                                             input logic pl, input logic [31:0] pay, input logic bad);
        logic [71:0] p;
        int ones;
        p = 72'd0;
        p[71:40] = pay;
        p[39:8]  = key;
        p[7:6]   = typ;
        p[1]     = pl;
        ones = pl ? $countones(p[71:1]) : $countones(p[39:1]);
        p[0] = ((ones % 2) == 0) ? ~bad : bad;
        return p;
    endfunction

    function automatic logic [31:0] ref_event(input logic [31:0] key);
        longint unsigned acc;
        longint unsigned v;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            v = longint'(key) & longint'(cfg_msk[i]);
            if (cfg_sft[i] >= 0) v = v >> cfg_sft[i];
            else                 v = v << (-cfg_sft[i]);
            acc = acc | (v & 64'h0000_0000_ffff_ffff);
        end
        return acc[31:0];
    endfunction

    function automatic void model_accept(input logic [71:0] p);
        int ones;
        logic par_good;
        ones = p[1] ? $countones(p[71:0]) : $countones(p[39:0]);
        par_good = (ones % 2) == 1;
        if (!par_good)                                            exp_perr = exp_perr + 32'd1;
        else if (p[7:6] != 2'b00 || (p[39:8] & mp_msk) != mp_key) exp_drop = exp_drop + 32'd1;
        else                                                      exp_q.push_back(ref_event(p[39:8]));
    endfunction

    task automatic apply_cfg(input logic [31:0] key, input logic [31:0] msk);
        mp_key = key;
        mp_msk = msk;
        for (int i = 0; i < 4; i++) begin
            mp_fld_msk[i] = cfg_msk[i];
            mp_fld_sft[i] = 6'(cfg_sft[i]);
        end
    endtask

    task automatic cfg_round_trip();
        cfg_msk = '{32'h0000_00ff, 32'h0000_ff00, 32'd0, 32'd0};
        cfg_sft = '{-16, 8, 0, 0};
        apply_cfg(32'hee00_0000, 32'hff00_0000);
    endtask

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_pkt(input logic [71:0] p);
        int waitc;
        bit done;
        waitc = 0;
        done  = 1'b0;
        pif.pkt_data_in = p;
        pif.pkt_vld_in  = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (pif.pkt_rdy_out) begin
                done    = 1'b1;
                acc_cyc = cyc;
                model_accept(p);
            end else begin
                waitc++;
                if (waitc > 300) begin
                    n_checks++; n_fail++;
                    $display("FAIL send_timeout: ready stuck low for %0d cycles, required ready", waitc);
                    done = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        pif.pkt_vld_in = 1'b0;
    endtask

    task automatic clear_model();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic drain(input int limit);
        int c;
        c = 0;
        while (got_q.size() < exp_q.size() && c < limit) begin
            @(posedge clk); #1;
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic compare_events(input string name);
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d events, required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s_data[%0d]: got %h required %h", name, i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cnt_clr = 1'b0;
        pif.pkt_vld_in = 1'b0; pif.pkt_data_in = 72'd0; pif.evt_rdy_in = 1'b1;
        cfg_round_trip();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (pif.pkt_rdy_out !== 1'b0) begin n_fail++; $display("FAIL reset_rdy_in_reset: got %b required 0", pif.pkt_rdy_out); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pif.pkt_rdy_out !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b required 1", pif.pkt_rdy_out); end
        n_checks++;
        if (pif.evt_vld_out !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b required 0", pif.evt_vld_out); end
        n_checks++;
        if (pif.evt_data_out !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h required 0", pif.evt_data_out); end
        n_checks++;
        if (drop_cnt !== 32'd0 || perr_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %h/%h required 0/0", drop_cnt, perr_cnt);
        end
        @(posedge clk); #1;
        clear_model();
    endtask

    task automatic test_round_trip();
        clear_model();
        cfg_round_trip();
        send_pkt(make_pkt(32'hee00_3412, 2'b00, 1'b0, 32'd0, 1'b0));
        drain(20);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== 32'h0012_0034) begin
            n_fail++;
            $display("FAIL round_trip_data: got %0d events first %h required 1 event 00120034",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'd0);
        end
        n_checks++;
        if (got_cyc.size() < 1 || got_cyc[0] != acc_cyc + 2) begin
            n_fail++;
            $display("FAIL round_trip_latency: got cycle %0d required %0d",
                     (got_cyc.size() > 0) ? got_cyc[0] : -1, acc_cyc + 2);
        end
    endtask

    task automatic test_mismatch();
        clear_model();
        send_pkt(make_pkt(32'hdd00_3412, 2'b00, 1'b0, 32'd0, 1'b0));
        drain(5);
        n_checks++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL mismatch_output: got %0d events required 0", got_q.size()); end
        n_checks++;
        if (drop_cnt !== 32'd1) begin n_fail++; $display("FAIL mismatch_drop_cnt: got %0d required 1", drop_cnt); end
        n_checks++;
        if (perr_cnt !== 32'd0) begin n_fail++; $display("FAIL mismatch_perr_cnt: got %0d required 0", perr_cnt); end
    endtask

    task automatic test_parity();
        logic [71:0] p;
        clear_model();
        p = 72'd0;
        p[39:8] = 32'hee00_3412;
        p[7:0]  = 8'h01;
        send_pkt(p);
        drain(5);
        n_checks++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL parity_output: got %0d events required 0", got_q.size()); end
        n_checks++;
        if (perr_cnt !== 32'd1) begin n_fail++; $display("FAIL parity_perr_cnt: got %0d required 1", perr_cnt); end
        n_checks++;
        if (drop_cnt !== exp_drop) begin n_fail++; $display("FAIL parity_drop_cnt: got %0d required %0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_random();
        bit fin;
        logic [31:0] key;
        logic [31:0] mk;
        clear_model();
        for (int i = 0; i < 4; i++) begin
            cfg_msk[i] = $urandom;
            cfg_sft[i] = int'($urandom_range(0, 63)) - 32;
        end
        cfg_sft[0] = -32;
        mk = {8'($urandom), 24'd0};
        apply_cfg(mk, 32'hff00_0000);
        fin = 1'b0;
        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    key = ($urandom_range(0, 1) == 1) ? {mk[31:24], 24'($urandom)} : 32'($urandom);
                    send_pkt(make_pkt(key, ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00,
                                      1'($urandom), 32'($urandom), $urandom_range(0, 6) == 0));
                end
                fin = 1'b1;
            end
            begin
                while (!fin) begin
                    @(posedge clk); #1;
                    pif.evt_rdy_in = 1'($urandom);
                end
            end
        join
        pif.evt_rdy_in = 1'b1;
        drain(50);
        compare_events("random");
        n_checks++;
        if (drop_cnt !== exp_drop || perr_cnt !== exp_perr) begin
            n_fail++;
            $display("FAIL random_cnt: got %0d/%0d required %0d/%0d", drop_cnt, perr_cnt, exp_drop, exp_perr);
        end
        n_checks++;
        if (stall_viol != 0) begin n_fail++; $display("FAIL random_stall_stable: got %0d changes required 0", stall_viol); end
    endtask

    task automatic test_backpressure();
        int c;
        clear_model();
        cfg_round_trip();
        pif.evt_rdy_in = 1'b0;
        fork
            begin
                for (int n = 0; n < 10; n++)
                    send_pkt(make_pkt(32'hee00_0100 + 32'(n), 2'b00, 1'b0, 32'd0, 1'b0));
            end
            begin
                repeat (5) @(negedge clk);
                n_checks++;
                if (pif.pkt_rdy_out !== 1'b0 || pif.evt_vld_out !== 1'b1) begin
                    n_fail++;
                    $display("FAIL backpressure_full: got rdy %b vld %b required rdy 0 vld 1",
                             pif.pkt_rdy_out, pif.evt_vld_out);
                end
                @(posedge clk); #1;
                c = 0;
                while (got_q.size() < 10 && c < 500) begin
                    pif.evt_rdy_in = 1'($urandom);
                    @(posedge clk); #1;
                    c++;
                end
                pif.evt_rdy_in = 1'b1;
            end
        join
        drain(20);
        n_checks++;
        if (got_q.size() != 10) begin n_fail++; $display("FAIL backpressure_count: got %0d required 10", got_q.size()); end
        compare_events("backpressure");
        n_checks++;
        if (stall_viol != 0) begin n_fail++; $display("FAIL backpressure_stable: got %0d changes required 0", stall_viol); end
    endtask

    task automatic test_streaming();
        clear_model();
        pif.evt_rdy_in = 1'b1;
        for (int n = 0; n < 100; n++)
            send_pkt(make_pkt(32'hee00_0000 | 32'($urandom_range(0, 32'h00ff_ffff)), 2'b00,
                              1'($urandom), 32'($urandom), 1'b0));
        drain(20);
        compare_events("streaming");
        for (int i = 1; i < got_cyc.size(); i++) begin
            n_checks++;
            if (got_cyc[i] != got_cyc[0] + i) begin
                n_fail++;
                $display("FAIL streaming_gap[%0d]: got cycle %0d required %0d", i, got_cyc[i], got_cyc[0] + i);
            end
        end
    endtask

    task automatic test_counter_edge();
        clear_model();
        force dut.drop_cnt_q = 32'hffff_ffff;
        #1;
        release dut.drop_cnt_q;
        exp_drop = 32'hffff_ffff;
        @(negedge clk);
        n_checks++;
        if (drop_cnt !== 32'hffff_ffff) begin n_fail++; $display("FAIL cnt_preload: got %h required ffffffff", drop_cnt); end
        @(posedge clk); #1;
        send_pkt(make_pkt(32'hdd00_3412, 2'b00, 1'b0, 32'd0, 1'b0));
        @(negedge clk);
        n_checks++;
        if (drop_cnt !== exp_drop || drop_cnt !== 32'd0) begin
            n_fail++; $display("FAIL cnt_wrap: got %h required %h", drop_cnt, exp_drop);
        end
        @(posedge clk); #1;
        cnt_clr = 1'b1;
        send_pkt(make_pkt(32'hdd00_3412, 2'b00, 1'b0, 32'd0, 1'b0));
        cnt_clr = 1'b0;
        exp_drop = 32'd0;
        exp_perr = 32'd0;
        @(negedge clk);
        n_checks++;
        if (drop_cnt !== exp_drop || perr_cnt !== exp_perr) begin
            n_fail++; $display("FAIL cnt_clr_priority: got %h/%h required 0/0", drop_cnt, perr_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        clear_model();
        cfg_round_trip();
        pif.evt_rdy_in = 1'b0;
        send_pkt(make_pkt(32'hee00_0001, 2'b00, 1'b0, 32'd0, 1'b0));
        send_pkt(make_pkt(32'hee00_0002, 2'b00, 1'b0, 32'd0, 1'b0));
        @(negedge clk);
        n_checks++;
        if (pif.evt_vld_out !== 1'b1 || pif.pkt_rdy_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_full: got vld %b rdy %b required 1/0", pif.evt_vld_out, pif.pkt_rdy_out);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (pif.evt_vld_out !== 1'b0 || pif.pkt_rdy_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_vld: got vld %b rdy %b required 0/0", pif.evt_vld_out, pif.pkt_rdy_out);
        end
        reset = 1'b0;
        exp_drop = 32'd0;
        exp_perr = 32'd0;
        clear_model();
        pif.evt_rdy_in = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (pif.pkt_rdy_out !== 1'b1 || got_q.size() != 0 || drop_cnt !== 32'd0 || perr_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_after: got rdy %b events %0d cnt %h/%h required 1 0 0/0",
                     pif.pkt_rdy_out, got_q.size(), drop_cnt, perr_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_round_trip();
        test_mismatch();
        test_parity();
        test_random();
        test_backpressure();
        test_streaming();
        test_counter_edge();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
